// File: rtl/fork_join_ctrl.sv
// fork/join_any sequencer: launches N_JOBS timed jobs, runs one follow-on job after the first finishes.
// Optional join_all mode is enabled by defining FORK_JOIN_ALL_EN (adds the join_all_i input).
module fork_join_ctrl #(
    parameter int N_JOBS = 3,
    parameter int CNT_W  = 8,
    parameter int TIME_W = 16,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [N_JOBS*CNT_W-1:0] job_delay_i,
    input  logic [CNT_W-1:0]        post_delay_i,
`ifdef FORK_JOIN_ALL_EN
    input  logic                    join_all_i,
`endif
    output logic                    busy_o,
    output logic [N_JOBS-1:0]       job_done_o,
    output logic [ID_W-1:0]         winner_o,
    output logic                    done_o,
    output logic [TIME_W-1:0]       elapsed_o,
    output logic                    start_drop_o
);

    typedef enum logic [1:0] {IDLE, RUN, POST} state_t;

    localparam logic [TIME_W-1:0] EL_MAX = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  job_cnt_q [N_JOBS];
    logic [N_JOBS-1:0] job_active_q;
    logic [CNT_W-1:0]  post_cnt_q;
    logic [TIME_W-1:0] elapsed_cnt_q;
    logic [TIME_W-1:0] elapsed_q;
    logic [ID_W-1:0]   winner_q;
    logic              start_accept;
    logic              join_hit;
    logic [ID_W-1:0]   win_lo;

    // Handshake: start_i is a level request; it is accepted only in IDLE with no job
    // still running, otherwise start_drop_o flags the ignored cycle.
    assign start_accept = (state_q == IDLE) && start_i && !(|job_active_q);
    assign start_drop_o = start_i && !start_accept;
    assign busy_o       = (state_q != IDLE) || (|job_active_q);
    assign done_o       = (state_q == POST) && (post_cnt_q == '0);
    assign winner_o     = winner_q;
    assign elapsed_o    = done_o ? elapsed_cnt_q : elapsed_q;

    always_comb begin
        job_done_o = '0;
        for (int i = 0; i < N_JOBS; i++)
            job_done_o[i] = job_active_q[i] && (job_cnt_q[i] == '0);
    end

    // Descending scan so the lowest completing index wins.
    always_comb begin
        win_lo = '0;
        for (int i = N_JOBS - 1; i >= 0; i--)
            if (job_done_o[i]) win_lo = ID_W'(i);
    end

`ifdef FORK_JOIN_ALL_EN
    logic            join_all_q;
    logic            join_all_hit;
    logic [ID_W-1:0] win_hi;

    // The join completes once no job remains active apart from those finishing now.
    assign join_all_hit = (|job_done_o) && ((job_active_q & ~job_done_o) == '0);
    assign join_hit     = join_all_q ? join_all_hit : (|job_done_o);

    always_comb begin
        win_hi = '0;
        for (int i = 0; i < N_JOBS; i++)
            if (job_done_o[i]) win_hi = ID_W'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)            join_all_q <= 1'b0;
        else if (start_accept) join_all_q <= join_all_i;
    end
`else
    assign join_hit = |job_done_o;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_accept) state_d = RUN;
            RUN:     if (join_hit) state_d = POST;
            POST:    if (post_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job counters keep running in every state so background jobs finish after the join.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            job_active_q <= '0;
            for (int i = 0; i < N_JOBS; i++) job_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_JOBS; i++) begin
                if (start_accept) begin
                    job_cnt_q[i]    <= job_delay_i[i*CNT_W +: CNT_W];
                    job_active_q[i] <= 1'b1;
                end else if (job_active_q[i]) begin
                    if (job_cnt_q[i] != '0) job_cnt_q[i] <= job_cnt_q[i] - 1'b1;
                    else                    job_active_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_cnt_q    <= '0;
            winner_q      <= '0;
            elapsed_cnt_q <= '0;
            elapsed_q     <= '0;
        end else begin
            if (state_q == RUN && join_hit) begin
                post_cnt_q <= post_delay_i;
`ifdef FORK_JOIN_ALL_EN
                winner_q   <= join_all_q ? win_hi : win_lo;
`else
                winner_q   <= win_lo;
`endif
            end else if (state_q == POST && post_cnt_q != '0) begin
                post_cnt_q <= post_cnt_q - 1'b1;
            end

            // Counting stops on the done cycle so the reported value is edges E0..done.
            if (start_accept)
                elapsed_cnt_q <= '0;
            else if (state_q != IDLE && !done_o && elapsed_cnt_q != EL_MAX)
                elapsed_cnt_q <= elapsed_cnt_q + 1'b1;

            if (done_o) elapsed_q <= elapsed_cnt_q;
        end
    end

endmodule
